// File: rtl/multi_lane_receiver_pkg.sv
// multi_lane_receiver_pkg: shared defaults and FSM state type for the multi-lane receiver
package multi_lane_receiver_pkg;
  localparam int RX_NUM_LANES = 4;
  localparam int ENC_DATA_BITS = 256;
  localparam int RX_SYNC_BITS = 8;
  localparam logic [RX_SYNC_BITS-1:0] RX_SYNCWORD = 8'hA5;
  localparam int RX_TIMEOUT_CYCLES = 1024;
  typedef enum logic [1:0] {IDLE, LISTEN, DONE, TIMEOUT} rx_state_t;
endpackage

// File: rtl/multi_lane_receiver_if.sv
// multi_lane_receiver_if: control, serial lanes and packet result between pins/decoder and the receiver
interface multi_lane_receiver_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_BITS = 256
);
  logic receive_start;
  logic game_active;
  logic [NUM_LANES-1:0] serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic receive_done;
  logic timeout;
  logic [NUM_LANES-1:0] lane_synced;
  modport master(
    output receive_start, game_active, serial_in,
    input data_out, receive_done, timeout, lane_synced
  );
  modport slave(
    input receive_start, game_active, serial_in,
    output data_out, receive_done, timeout, lane_synced
  );
endinterface

// File: rtl/multi_lane_receiver_lane.sv
// lane_receiver: per-lane syncword hunt followed by capture of this lane's packet slice
module lane_receiver #(
  parameter int SYNC_BITS = 8,
  parameter logic [SYNC_BITS-1:0] SYNCWORD = 8'hA5,
  parameter int LANE_BITS = 64
) (
  input logic clk,
  input logic clear,
  input logic listen,
  input logic serial_in,
  output logic synced,
  output logic lane_done,
  output logic [LANE_BITS-1:0] slice
);
  localparam int CW = $clog2(LANE_BITS + 1);
  logic [SYNC_BITS-1:0] sync_reg;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = sync_reg == SYNCWORD;
  assign lane_done = cnt == CW'(LANE_BITS);
  // the bit sampled on the edge that sees the match is already the first data bit
  always_ff @(posedge clk) begin
    if (clear) begin
      sync_reg <= '0;
      slice <= '0;
      cnt <= '0;
      synced <= 1'b0;
    end else if (listen) begin
      if (!hit) sync_reg <= {sync_reg[SYNC_BITS-2:0], serial_in};
      synced <= synced | hit;
      if (hit && !lane_done) begin
        slice <= {slice[LANE_BITS-2:0], serial_in};
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/multi_lane_receiver.sv
// multi_lane_receiver: reassembles a packet striped over skewed serial lanes, with completion timeout
module multi_lane_receiver
  import multi_lane_receiver_pkg::*;
#(
  parameter int NUM_LANES = RX_NUM_LANES,
  parameter int DATA_BITS = ENC_DATA_BITS,
  parameter int SYNC_BITS = RX_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD = RX_SYNCWORD,
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst,
  multi_lane_receiver_if.slave bus
);
  localparam int LANE_BITS = DATA_BITS / NUM_LANES;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  rx_state_t state, next_state;
  logic [TW-1:0] timer;
  logic [NUM_LANES-1:0] lane_done, synced;
  logic [DATA_BITS-1:0] data;
  logic abort, clear, listen, all_done;
  assign abort = rst | ~bus.game_active;
  assign clear = abort | bus.receive_start;
  assign listen = state == LISTEN;
  assign all_done = &lane_done;
  assign bus.data_out = data;
  assign bus.lane_synced = synced;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_receiver #(
      .SYNC_BITS(SYNC_BITS),
      .SYNCWORD(SYNCWORD),
      .LANE_BITS(LANE_BITS)
    ) u_lane (
      .clk(clk),
      .clear(clear),
      .listen(listen),
      .serial_in(bus.serial_in[i]),
      .synced(synced[i]),
      .lane_done(lane_done[i]),
      .slice(data[i*LANE_BITS +: LANE_BITS])
    );
  end
  always_ff @(posedge clk) begin
    if (abort) state <= IDLE;
    else state <= next_state;
  end
  // completion is tested before the limit so a simultaneous finish is reported as done
  always_comb begin
    next_state = bus.receive_start ? LISTEN :
                 !listen ? state :
                 all_done ? DONE :
                 timer == TW'(TIMEOUT_CYCLES - 1) ? TIMEOUT : LISTEN;
  end
  always_ff @(posedge clk) begin
    if (clear) timer <= '0;
    else if (listen) timer <= timer + TW'(1);
  end
  always_comb begin
    bus.receive_done = state == DONE;
    bus.timeout = state == TIMEOUT;
  end
endmodule
